pcie_trans_gen: RTL and testbench

Parametrised next-generation transaction router with configurable data width, FIFO depths, virtual-channel count and destination count. Words enter a main FIFO and are steered by their VC-id field into per-VC FIFOs. An arbiter (strict-priority or round-robin) moves VC heads into per-destination FIFOs selected by a dest field. A control FSM (RESET/INIT/IDLE/ACTIVE/ERROR) owns programmable thresholds and status outputs.

---
 rtl/pcie_trans_gen_if.sv | 15 +
 rtl/pcie_trans_gen.sv | 192 +++++++++++++++++++
 tb/tb_pcie_trans_gen.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pcie_trans_gen_if.sv
// Handshake and data bundle between the transaction router and its upstream/downstream agents.
interface pcie_trans_gen_if #(
    parameter int DATA_W   = 6,
    parameter int NUM_DEST = 2
);
    logic [DATA_W-1:0]          data_in;
    logic                       push;
    logic [NUM_DEST-1:0]        pop;
    logic [NUM_DEST*DATA_W-1:0] data_out;
    logic [NUM_DEST-1:0]        valid_out;
    logic                       pausa_mf;

    modport master (output data_in, push, pop, input data_out, valid_out, pausa_mf);
    modport slave  (input data_in, push, pop, output data_out, valid_out, pausa_mf);
endinterface

// File: rtl/pcie_trans_gen.sv
// Transaction router: main FIFO -> per-VC FIFOs -> arbiter -> per-destination FIFOs.
// state    | meaning
// RESET    | just out of reset, everything frozen
// INIT     | thresholds latched each cycle, datapath frozen
// IDLE     | running, all FIFOs empty
// ACTIVE   | running, at least one FIFO holds data
// ERROR    | main FIFO overflowed, frozen until reset
module pcie_trans_gen #(
    parameter int DATA_W   = 6,
    parameter int NUM_VC   = 2,
    parameter int NUM_DEST = 2,
    parameter int MF_DEPTH = 4,
    parameter int VC_DEPTH = 16,
    parameter int D_DEPTH  = 4,
    parameter int ARB_MODE = 0
) (
    input  logic                      clk,
    input  logic                      reset_L,
    input  logic                      init,
    input  logic [$clog2(MF_DEPTH):0] umbral_mf,
    input  logic [$clog2(VC_DEPTH):0] umbral_vc,
    input  logic [$clog2(D_DEPTH):0]  umbral_d,
    pcie_trans_gen_if.slave           bus,
    output logic                      active_out,
    output logic                      idle_out,
    output logic                      error_out
);
    localparam int VB = $clog2(NUM_VC);
    localparam int DB = $clog2(NUM_DEST);
    localparam int MA = $clog2(MF_DEPTH);
    localparam int VA = $clog2(VC_DEPTH);
    localparam int DA = $clog2(D_DEPTH);

    typedef enum logic [2:0] {S_RESET, S_INIT, S_IDLE, S_ACTIVE, S_ERROR} state_t;
    state_t state_q, state_d;

    logic [MA:0]       thr_mf_q;
    logic [VA:0]       thr_vc_q;
    logic [DA:0]       thr_d_q;
    logic [DATA_W-1:0] mf_mem_q [MF_DEPTH];
    logic [MA-1:0]     mf_rd_q, mf_wr_q;
    logic [MA:0]       mf_cnt_q;
    logic [DATA_W-1:0] vc_mem_q [NUM_VC][VC_DEPTH];
    logic [VA-1:0]     vc_rd_q [NUM_VC];
    logic [VA-1:0]     vc_wr_q [NUM_VC];
    logic [VA:0]       vc_cnt_q [NUM_VC];
    logic [DATA_W-1:0] d_mem_q [NUM_DEST][D_DEPTH];
    logic [DA-1:0]     d_rd_q [NUM_DEST];
    logic [DA-1:0]     d_wr_q [NUM_DEST];
    logic [DA:0]       d_cnt_q [NUM_DEST];
    logic [VB-1:0]     rr_q;
    logic [NUM_DEST-1:0][DATA_W-1:0] dout_q;
    logic [NUM_DEST-1:0]             vout_q;

    logic              run, mf_full, mf_pop, mf_push, overflow, any_busy, grant;
    logic [DATA_W-1:0] mf_head;
    logic [VB-1:0]     mf_vc, grant_v, idx;
    logic [DATA_W-1:0] vc_head [NUM_VC];
    logic [DB-1:0]     vc_dest [NUM_VC];
    logic [NUM_VC-1:0] elig, vc_push, vc_pop;
    logic [DATA_W-1:0] d_head [NUM_DEST];
    logic [NUM_DEST-1:0] d_push, d_pop;

    assign run      = (state_q == S_IDLE) || (state_q == S_ACTIVE);
    assign mf_head  = mf_mem_q[mf_rd_q];
    assign mf_vc    = mf_head[DATA_W-1 -: VB];
    assign mf_full  = (mf_cnt_q == (MA+1)'(MF_DEPTH));
    // Head-of-line: the MF head moves only when its own VC has room.
    assign mf_pop   = run && (mf_cnt_q != '0) && (vc_cnt_q[mf_vc] < thr_vc_q);
    assign mf_push  = run && bus.push && (!mf_full || mf_pop);
    assign overflow = run && bus.push && mf_full && !mf_pop;

    always_comb begin
        any_busy = (mf_cnt_q != '0);
        for (int v = 0; v < NUM_VC; v++) begin
            vc_head[v] = vc_mem_q[v][vc_rd_q[v]];
            vc_dest[v] = vc_head[v][DATA_W-1-VB -: DB];
            elig[v]    = (vc_cnt_q[v] != '0) && (d_cnt_q[vc_dest[v]] < thr_d_q);
            vc_push[v] = mf_pop && (mf_vc == VB'(v));
            any_busy   = any_busy || (vc_cnt_q[v] != '0);
        end
        for (int d = 0; d < NUM_DEST; d++) begin
            d_head[d] = d_mem_q[d][d_rd_q[d]];
            d_pop[d]  = run && bus.pop[d] && (d_cnt_q[d] != '0);
            any_busy  = any_busy || (d_cnt_q[d] != '0);
        end
    end

    always_comb begin
        grant   = 1'b0;
        grant_v = '0;
        idx     = '0;
        for (int i = 0; i < NUM_VC; i++) begin
            idx = (ARB_MODE == 1) ? VB'(rr_q + VB'(i + 1)) : VB'(i);
            if (run && !grant && elig[idx]) begin
                grant   = 1'b1;
                grant_v = idx;
            end
        end
        for (int v = 0; v < NUM_VC; v++)
            vc_pop[v] = grant && (grant_v == VB'(v));
        for (int d = 0; d < NUM_DEST; d++)
            d_push[d] = grant && (vc_dest[grant_v] == DB'(d));
    end

    always_ff @(posedge clk or posedge reset_L) begin
        if (reset_L) state_q <= S_RESET;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:  state_d = S_INIT;
            S_INIT:   if (!init) state_d = S_IDLE;
            S_IDLE, S_ACTIVE: begin
                if (overflow)      state_d = S_ERROR;
                else if (init)     state_d = S_INIT;
                else if (any_busy) state_d = S_ACTIVE;
                else               state_d = S_IDLE;
            end
            default:  state_d = state_q;
        endcase
    end

    always_comb begin
        idle_out      = (state_q == S_IDLE);
        active_out    = (state_q == S_ACTIVE);
        error_out     = (state_q == S_ERROR);
        bus.pausa_mf  = run ? (mf_cnt_q >= thr_mf_q) : 1'b1;
        bus.valid_out = run ? vout_q : '0;
    end

    assign bus.data_out = dout_q;

    always_ff @(posedge clk or posedge reset_L) begin
        if (reset_L) begin
            thr_mf_q <= (MA+1)'(MF_DEPTH - 1);
            thr_vc_q <= (VA+1)'(VC_DEPTH - 1);
            thr_d_q  <= (DA+1)'(D_DEPTH - 1);
            mf_rd_q  <= '0;
            mf_wr_q  <= '0;
            mf_cnt_q <= '0;
            rr_q     <= '0;
            dout_q   <= '0;
            vout_q   <= '0;
            for (int v = 0; v < NUM_VC; v++) begin
                vc_rd_q[v]  <= '0;
                vc_wr_q[v]  <= '0;
                vc_cnt_q[v] <= '0;
            end
            for (int d = 0; d < NUM_DEST; d++) begin
                d_rd_q[d]  <= '0;
                d_wr_q[d]  <= '0;
                d_cnt_q[d] <= '0;
            end
        end else begin
            // Clamping to depth is what keeps the internal FIFOs from overflowing.
            if (state_q == S_INIT) begin
                thr_mf_q <= (umbral_mf > (MA+1)'(MF_DEPTH)) ? (MA+1)'(MF_DEPTH) : umbral_mf;
                thr_vc_q <= (umbral_vc > (VA+1)'(VC_DEPTH)) ? (VA+1)'(VC_DEPTH) : umbral_vc;
                thr_d_q  <= (umbral_d  > (DA+1)'(D_DEPTH))  ? (DA+1)'(D_DEPTH)  : umbral_d;
            end
            if (mf_push) mf_wr_q <= mf_wr_q + 1'b1;
            if (mf_pop)  mf_rd_q <= mf_rd_q + 1'b1;
            mf_cnt_q <= mf_cnt_q + (MA+1)'(mf_push) - (MA+1)'(mf_pop);
            if (grant) rr_q <= grant_v;
            for (int v = 0; v < NUM_VC; v++) begin
                if (vc_push[v]) vc_wr_q[v] <= vc_wr_q[v] + 1'b1;
                if (vc_pop[v])  vc_rd_q[v] <= vc_rd_q[v] + 1'b1;
                vc_cnt_q[v] <= vc_cnt_q[v] + (VA+1)'(vc_push[v]) - (VA+1)'(vc_pop[v]);
            end
            for (int d = 0; d < NUM_DEST; d++) begin
                if (d_push[d]) d_wr_q[d] <= d_wr_q[d] + 1'b1;
                if (d_pop[d]) begin
                    d_rd_q[d] <= d_rd_q[d] + 1'b1;
                    dout_q[d] <= d_head[d];
                end
                d_cnt_q[d] <= d_cnt_q[d] + (DA+1)'(d_push[d]) - (DA+1)'(d_pop[d]);
                vout_q[d]  <= d_pop[d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mf_push) mf_mem_q[mf_wr_q] <= bus.data_in;
        for (int v = 0; v < NUM_VC; v++)
            if (vc_push[v]) vc_mem_q[v][vc_wr_q[v]] <= mf_head;
        for (int d = 0; d < NUM_DEST; d++)
            if (d_push[d]) d_mem_q[d][d_wr_q[d]] <= vc_head[grant_v];
    end
endmodule

// File: tb/tb_pcie_trans_gen.sv
// Directed bench for pcie_trans_gen: strict-priority and round-robin instances share stimulus.
module tb_pcie_trans_gen;
    localparam int DATA_W = 6;

    logic              clk       = 1'b0;
    logic              reset_L   = 1'b1;
    logic              init      = 1'b0;
    logic [2:0]        umbral_mf = '0;
    logic [4:0]        umbral_vc = '0;
    logic [2:0]        umbral_d  = '0;
    logic [DATA_W-1:0] data_in   = '0;
    logic              push      = 1'b0;
    logic [1:0]        pop       = '0;
    logic act_sp, idle_sp, err_sp, act_rr, idle_rr, err_rr;
    int tests_run    = 0;
    int tests_failed = 0;

    pcie_trans_gen_if #(.DATA_W(DATA_W), .NUM_DEST(2)) bus_sp ();
    pcie_trans_gen_if #(.DATA_W(DATA_W), .NUM_DEST(2)) bus_rr ();

    assign bus_sp.data_in = data_in;
    assign bus_sp.push    = push;
    assign bus_sp.pop     = pop;
    assign bus_rr.data_in = data_in;
    assign bus_rr.push    = push;
    assign bus_rr.pop     = pop;

    pcie_trans_gen #(.ARB_MODE(0)) u_sp (
        .clk(clk), .reset_L(reset_L), .init(init),
        .umbral_mf(umbral_mf), .umbral_vc(umbral_vc), .umbral_d(umbral_d),
        .bus(bus_sp), .active_out(act_sp), .idle_out(idle_sp), .error_out(err_sp));

    pcie_trans_gen #(.ARB_MODE(1)) u_rr (
        .clk(clk), .reset_L(reset_L), .init(init),
        .umbral_mf(umbral_mf), .umbral_vc(umbral_vc), .umbral_d(umbral_d),
        .bus(bus_rr), .active_out(act_rr), .idle_out(idle_rr), .error_out(err_rr));

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic program_thr(input logic [2:0] mf, input logic [4:0] vc, input logic [2:0] d);
        reset_L = 1'b1;
        step(1);
        reset_L   = 1'b0;
        init      = 1'b1;
        umbral_mf = mf;
        umbral_vc = vc;
        umbral_d  = d;
        step(2);
        init = 1'b0;
        step(1);
    endtask

    task automatic push_seq(input logic [5:0] first, input int n);
        for (int k = 0; k < n; k++) begin
            data_in = first + 6'(k);
            push    = 1'b1;
            step(1);
        end
        push = 1'b0;
    endtask

    task automatic test_reset;
        init = 1'b1; umbral_mf = 3'd2; umbral_vc = 5'd3; umbral_d = 3'd1;
        step(2);
        tests_run++;
        if ({act_sp, idle_sp, err_sp, bus_sp.pausa_mf} !== 4'b0001) begin
            tests_failed++; $display("FAIL rst_flags: got %b want 0001", {act_sp, idle_sp, err_sp, bus_sp.pausa_mf});
        end
        tests_run++;
        if ({bus_sp.valid_out, bus_sp.data_out} !== 14'h0) begin
            tests_failed++; $display("FAIL rst_outputs: got %h want 0", {bus_sp.valid_out, bus_sp.data_out});
        end
        tests_run++;
        if ({u_sp.thr_mf_q, u_sp.thr_vc_q, u_sp.thr_d_q} !== {3'd3, 5'd15, 3'd3}) begin
            tests_failed++; $display("FAIL rst_thr: got %h want %h", {u_sp.thr_mf_q, u_sp.thr_vc_q, u_sp.thr_d_q}, {3'd3, 5'd15, 3'd3});
        end
        reset_L = 1'b0;
        step(1);
        tests_run++;
        if ({act_sp, idle_sp, err_sp, bus_sp.pausa_mf} !== 4'b0001) begin
            tests_failed++; $display("FAIL init_flags: got %b want 0001", {act_sp, idle_sp, err_sp, bus_sp.pausa_mf});
        end
        step(1);
        init = 1'b0;
        step(1);
        tests_run++;
        if ({idle_sp, bus_sp.pausa_mf} !== 2'b10) begin
            tests_failed++; $display("FAIL idle_entry: got idle/pausa %b want 10", {idle_sp, bus_sp.pausa_mf});
        end
        umbral_mf = 3'd1; umbral_vc = 5'd7; umbral_d = 3'd3;
        step(2);
        tests_run++;
        if ({u_sp.thr_mf_q, u_sp.thr_vc_q, u_sp.thr_d_q} !== {3'd2, 5'd3, 3'd1}) begin
            tests_failed++; $display("FAIL thr_hold: got %h want %h", {u_sp.thr_mf_q, u_sp.thr_vc_q, u_sp.thr_d_q}, {3'd2, 5'd3, 3'd1});
        end
    endtask

    task automatic test_latency;
        logic [2:0] valid_hist;
        data_in = 6'h2A; push = 1'b1; pop = 2'b01;
        step(1);
        push = 1'b0;
        valid_hist[0] = bus_sp.valid_out[0];
        step(1);
        valid_hist[1] = bus_sp.valid_out[0];
        tests_run++;
        if (act_sp !== 1'b1) begin
            tests_failed++; $display("FAIL lat_active: got %b want 1", act_sp);
        end
        step(1);
        valid_hist[2] = bus_sp.valid_out[0];
        tests_run++;
        if (valid_hist !== 3'b000) begin
            tests_failed++; $display("FAIL lat_early_valid: got %b want 000", valid_hist);
        end
        step(1);
        tests_run++;
        if ({bus_sp.valid_out[0], bus_sp.data_out[5:0]} !== {1'b1, 6'h2A}) begin
            tests_failed++; $display("FAIL lat_out: got %b/%h want 1/2a", bus_sp.valid_out[0], bus_sp.data_out[5:0]);
        end
        step(1);
        tests_run++;
        if ({idle_sp, bus_sp.valid_out[0], bus_sp.data_out[5:0]} !== {2'b10, 6'h2A}) begin
            tests_failed++; $display("FAIL lat_drain_hold: got %b/%b/%h want 1/0/2a", idle_sp, bus_sp.valid_out[0], bus_sp.data_out[5:0]);
        end
        pop = 2'b00;
    endtask

    task automatic test_arbitration;
        logic [5:0] exp_sp [8];
        logic [5:0] exp_rr [8];
        logic [5:0] got_sp [8];
        logic [5:0] got_rr [8];
        int n_sp = 0;
        int n_rr = 0;
        exp_sp = '{6'h10, 6'h11, 6'h12, 6'h13, 6'h30, 6'h31, 6'h32, 6'h33};
        exp_rr = '{6'h10, 6'h30, 6'h11, 6'h31, 6'h12, 6'h32, 6'h13, 6'h33};
        program_thr(3'd4, 5'd8, 3'd1);
        push_seq(6'h10, 4);
        push_seq(6'h30, 4);
        step(8);
        pop = 2'b10;
        for (int c = 0; c < 40; c++) begin
            step(1);
            if (bus_sp.valid_out[1] && n_sp < 8) begin got_sp[n_sp] = bus_sp.data_out[11:6]; n_sp++; end
            if (bus_rr.valid_out[1] && n_rr < 8) begin got_rr[n_rr] = bus_rr.data_out[11:6]; n_rr++; end
        end
        pop = 2'b00;
        tests_run++;
        if (n_sp != 8 || n_rr != 8) begin
            tests_failed++; $display("FAIL arb_count: got sp=%0d rr=%0d want 8/8", n_sp, n_rr);
        end
        for (int k = 0; k < 8; k++) begin
            if (k < n_sp) begin
                tests_run++;
                if (got_sp[k] !== exp_sp[k]) begin
                    tests_failed++; $display("FAIL arb_sp[%0d]: got %h want %h", k, got_sp[k], exp_sp[k]);
                end
            end
            if (k < n_rr) begin
                tests_run++;
                if (got_rr[k] !== exp_rr[k]) begin
                    tests_failed++; $display("FAIL arb_rr[%0d]: got %h want %h", k, got_rr[k], exp_rr[k]);
                end
            end
        end
    endtask

    task automatic test_dest_threshold;
        program_thr(3'd2, 5'd3, 3'd2);
        push_seq(6'h00, 8);
        step(6);
        tests_run++;
        if ({u_sp.d_cnt_q[0], u_sp.vc_cnt_q[0], u_sp.mf_cnt_q} !== {3'd2, 5'd3, 3'd3}) begin
            tests_failed++; $display("FAIL dthr_counts: got d/vc/mf %0d/%0d/%0d want 2/3/3", u_sp.d_cnt_q[0], u_sp.vc_cnt_q[0], u_sp.mf_cnt_q);
        end
        tests_run++;
        if ({bus_sp.pausa_mf, err_sp, bus_sp.valid_out} !== 4'b1000) begin
            tests_failed++; $display("FAIL dthr_flags: got pausa/err/valid %b want 1000", {bus_sp.pausa_mf, err_sp, bus_sp.valid_out});
        end
    endtask

    task automatic test_full_push_pop;
        program_thr(3'd4, 5'd1, 3'd1);
        push_seq(6'h00, 6);
        step(4);
        tests_run++;
        if ({u_sp.mf_cnt_q, bus_sp.pausa_mf, err_sp} !== {3'd4, 2'b10}) begin
            tests_failed++; $display("FAIL fpp_full: got cnt=%0d pausa=%b err=%b want 4/1/0", u_sp.mf_cnt_q, bus_sp.pausa_mf, err_sp);
        end
        pop = 2'b01;
        step(1);
        pop = 2'b00;
        tests_run++;
        if ({bus_sp.valid_out[0], bus_sp.data_out[5:0]} !== {1'b1, 6'h00}) begin
            tests_failed++; $display("FAIL fpp_pop: got %b/%h want 1/00", bus_sp.valid_out[0], bus_sp.data_out[5:0]);
        end
        step(1);
        data_in = 6'h06; push = 1'b1;
        step(1);
        push = 1'b0;
        tests_run++;
        if ({err_sp, u_sp.mf_cnt_q} !== {1'b0, 3'd4}) begin
            tests_failed++; $display("FAIL fpp_same_cycle: got err=%b cnt=%0d want 0/4", err_sp, u_sp.mf_cnt_q);
        end
    endtask

    task automatic test_overflow;
        program_thr(3'd4, 5'd0, 3'd1);
        push_seq(6'h00, 4);
        tests_run++;
        if ({u_sp.mf_cnt_q, err_sp} !== {3'd4, 1'b0}) begin
            tests_failed++; $display("FAIL ovf_fill: got cnt=%0d err=%b want 4/0", u_sp.mf_cnt_q, err_sp);
        end
        push_seq(6'h04, 1);
        tests_run++;
        if ({act_sp, idle_sp, err_sp, bus_sp.pausa_mf} !== 4'b0011) begin
            tests_failed++; $display("FAIL ovf_error: got %b want 0011", {act_sp, idle_sp, err_sp, bus_sp.pausa_mf});
        end
        init = 1'b1;
        step(2);
        init = 1'b0;
        step(2);
        tests_run++;
        if ({idle_sp, err_sp} !== 2'b01) begin
            tests_failed++; $display("FAIL ovf_init_ignored: got idle/err %b want 01", {idle_sp, err_sp});
        end
        reset_L = 1'b1;
        #1;
        tests_run++;
        if ({act_sp, idle_sp, err_sp, u_sp.mf_cnt_q} !== 6'b000_000) begin
            tests_failed++; $display("FAIL ovf_reset: got flags %b cnt %0d want 000/0", {act_sp, idle_sp, err_sp}, u_sp.mf_cnt_q);
        end
        step(1);
        reset_L = 1'b0;
        step(1);
        tests_run++;
        if ({idle_sp, err_sp, bus_sp.pausa_mf} !== 3'b001) begin
            tests_failed++; $display("FAIL ovf_init_state: got idle/err/pausa %b want 001", {idle_sp, err_sp, bus_sp.pausa_mf});
        end
        step(1);
        tests_run++;
        if (idle_sp !== 1'b1) begin
            tests_failed++; $display("FAIL ovf_back_idle: got %b want 1", idle_sp);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_arbitration();
        test_dest_threshold();
        test_full_push_pop();
        test_overflow();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
